// File: rtl/rate_sweep_ctrl.sv
// Automatic frequency-select sweep for the rate-meter test generator.
// Steps sel 0..7, settles, counts rising edges over a gate window, and reports each count via valid/ready.
`timescale 1ns/1ps
module rate_sweep_ctrl #(
  parameter int unsigned GATE_CYCLES   = 1000000,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             pulse_in,
  output logic [2:0]       sel,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic [2:0]       result_sel,
  output logic             result_ovf,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             done
);

  localparam int unsigned GATE_W   = 32;
  localparam int unsigned SETTLE_W = 16;
  localparam logic [GATE_W-1:0]   GATE_LOAD   = GATE_W'(GATE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX     = '1;
  localparam logic [2:0]          SEL_LAST    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_prev;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic [GATE_W-1:0]   r_gate_cnt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf;
  logic [2:0]          r_sel;
  logic                r_busy;
  logic [CNT_W-1:0]    r_result;
  logic [2:0]          r_result_sel;
  logic                r_result_ovf;
  logic                r_result_valid;
  logic                r_done;

  logic w_xfer;
  logic w_settle_last;
  logic w_gate_last;
  logic w_edge;
  logic w_cnt_sat;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic w_ovf_nxt;

  logic w_load_settle;
  logic w_sel_clr;
  logic w_sel_inc;
  logic w_gate_start;
  logic w_count;
  logic w_capture;
  logic w_valid_clr;
  logic w_done_set;

  assign w_xfer        = r_result_valid & result_ready;
  assign w_settle_last = (r_settle_cnt == '0);
  assign w_gate_last   = (r_gate_cnt == '0);
  assign w_edge        = pulse_in & ~r_prev;
  assign w_cnt_sat     = (r_cnt == CNT_MAX);
  // A rising edge that arrives while the counter is full is dropped and flagged.
  assign w_cnt_nxt     = (w_edge && !w_cnt_sat) ? r_cnt + CNT_W'(1) : r_cnt;
  assign w_ovf_nxt     = r_ovf | (w_edge & w_cnt_sat);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; abort beats every other transition outside IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (abort)              w_state_nxt = ST_IDLE;
        else if (w_settle_last) w_state_nxt = ST_GATE;
      end
      ST_GATE: begin
        if (abort)            w_state_nxt = ST_IDLE;
        else if (w_gate_last) w_state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        if (abort)       w_state_nxt = ST_IDLE;
        else if (w_xfer) w_state_nxt = (r_sel == SEL_LAST) ? ST_IDLE : ST_SETTLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output/control decode driving the datapath registers
  always_comb begin
    w_load_settle = 1'b0;
    w_sel_clr     = 1'b0;
    w_sel_inc     = 1'b0;
    w_gate_start  = 1'b0;
    w_count       = 1'b0;
    w_capture     = 1'b0;
    w_valid_clr   = 1'b0;
    w_done_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_sel_clr     = start;
        w_load_settle = start;
      end
      ST_SETTLE: w_gate_start = w_settle_last & ~abort;
      ST_GATE: begin
        w_count   = ~abort;
        w_capture = w_gate_last & ~abort;
      end
      ST_REPORT: begin
        w_valid_clr   = w_xfer | abort;
        w_sel_inc     = w_xfer & ~abort & (r_sel != SEL_LAST);
        w_load_settle = w_sel_inc;
        w_done_set    = w_xfer & ~abort & (r_sel == SEL_LAST);
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev         <= 1'b0;
      r_settle_cnt   <= '0;
      r_gate_cnt     <= '0;
      r_cnt          <= '0;
      r_ovf          <= 1'b0;
      r_sel          <= 3'd0;
      r_busy         <= 1'b0;
      r_result       <= '0;
      r_result_sel   <= 3'd0;
      r_result_ovf   <= 1'b0;
      r_result_valid <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_prev <= pulse_in;
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= w_done_set;

      if (w_load_settle)
        r_settle_cnt <= SETTLE_LOAD;
      else if (r_state == ST_SETTLE && !w_settle_last)
        r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);

      if (w_gate_start)
        r_gate_cnt <= GATE_LOAD;
      else if (r_state == ST_GATE && !w_gate_last)
        r_gate_cnt <= r_gate_cnt - GATE_W'(1);

      if (w_sel_clr)      r_sel <= 3'd0;
      else if (w_sel_inc) r_sel <= r_sel + 3'd1;

      if (w_gate_start) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_count) begin
        r_cnt <= w_cnt_nxt;
        r_ovf <= w_ovf_nxt;
      end

      // Capture includes the edge seen on the final gate cycle
      if (w_capture) begin
        r_result       <= w_cnt_nxt;
        r_result_ovf   <= w_ovf_nxt;
        r_result_sel   <= r_sel;
        r_result_valid <= 1'b1;
      end else if (w_valid_clr) begin
        r_result_valid <= 1'b0;
      end
    end
  end

  assign sel          = r_sel;
  assign busy         = r_busy;
  assign result       = r_result;
  assign result_sel   = r_result_sel;
  assign result_ovf   = r_result_ovf;
  assign result_valid = r_result_valid;
  assign done         = r_done;

endmodule

// File: tb/tb_rate_sweep_ctrl.sv
// Directed bench for rate_sweep_ctrl: sweep, saturation, backpressure, boundaries, abort/reset.
`timescale 1ns/1ps
module tb_rate_sweep_ctrl;

  localparam int unsigned G = 100;
  localparam int unsigned S = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic pulse_in = 1'b0;
  logic result_ready = 1'b0;
  logic tog_en = 1'b0;

  logic [2:0] a_sel, a_result_sel, b_sel, b_result_sel;
  logic       a_busy, a_ovf, a_valid, a_done;
  logic       b_busy, b_ovf, b_valid, b_done;
  logic [7:0] a_result;
  logic [4:0] b_result;

  int n_checks = 0;
  int n_errors = 0;

  rate_sweep_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pulse_in(pulse_in),
    .sel(a_sel), .busy(a_busy), .result(a_result), .result_sel(a_result_sel),
    .result_ovf(a_ovf), .result_valid(a_valid), .result_ready(result_ready), .done(a_done)
  );

  rate_sweep_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(5)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pulse_in(pulse_in),
    .sel(b_sel), .busy(b_busy), .result(b_result), .result_sel(b_result_sel),
    .result_ovf(b_ovf), .result_valid(b_valid), .result_ready(result_ready), .done(b_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; inputs set afterwards apply to this cycle
  task automatic tick();
    @(negedge clk);
    if (tog_en) pulse_in = ~pulse_in;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!a_valid && n < 400) begin
      tick();
      n++;
    end
    if (!a_valid) check_eq("valid_timeout", 32'(a_valid), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    logic stable;
    logic [7:0] hold_res;
    logic [2:0] hold_rsel, hold_sel;

    // Reset with toggling input, then idle without start
    tog_en = 1'b1;
    repeat (3) tick();
    check_eq("rst_sel",   32'(a_sel), 32'd0);
    check_eq("rst_busy",  32'(a_busy), 32'd0);
    check_eq("rst_res",   32'(a_result), 32'd0);
    check_eq("rst_rsel",  32'(a_result_sel), 32'd0);
    check_eq("rst_ovf",   32'(a_ovf), 32'd0);
    check_eq("rst_valid", 32'(a_valid), 32'd0);
    check_eq("rst_done",  32'(a_done), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (200) begin
      tick();
      if (a_valid || a_busy || a_done) seen = 1'b1;
    end
    check_eq("idle_quiet", 32'(seen), 32'd0);

    // Full sweep with alternating input; dut_b saturates
    result_ready = 1'b1;
    pulse_start();
    check_eq("sweep_busy", 32'(a_busy), 32'd1);
    for (int k = 0; k < 8; k++) begin
      wait_valid(n);
      check_eq(k == 0 ? "first_valid_wait" : "valid_interval", 32'(n), 32'd104);
      check_eq("sweep_res",  32'(a_result), 32'd50);
      check_eq("sweep_rsel", 32'(a_result_sel), 32'(k));
      check_eq("sweep_ovf",  32'(a_ovf), 32'd0);
      check_eq("sat_res",    32'(b_result), 32'd31);
      check_eq("sat_ovf",    32'(b_ovf), 32'd1);
      tick();
      if (k < 7) begin
        check_eq("sweep_sel_next", 32'(a_sel), 32'(k + 1));
        check_eq("sweep_valid_drop", 32'(a_valid), 32'd0);
      end else begin
        check_eq("sweep_done", 32'(a_done), 32'd1);
        check_eq("sweep_done_busy", 32'(a_busy), 32'd0);
        check_eq("sweep_sel_hold", 32'(a_sel), 32'd7);
        tick();
        check_eq("sweep_done_once", 32'(a_done), 32'd0);
      end
    end

    // Backpressure on code 2, then abort in gate of code 5
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) result_ready = 1'b0;
      wait_valid(n);
      check_eq("bp_res", 32'(a_result), 32'd50);
      check_eq("bp_rsel", 32'(a_result_sel), 32'(k));
      if (k == 2) begin
        hold_res  = a_result;
        hold_rsel = a_result_sel;
        hold_sel  = a_sel;
        stable    = 1'b1;
        repeat (20) begin
          tick();
          if (a_result !== hold_res || a_result_sel !== hold_rsel ||
              a_sel !== hold_sel || !a_valid) stable = 1'b0;
        end
        check_eq("bp_stable", 32'(stable), 32'd1);
        check_eq("bp_sel_hold", 32'(a_sel), 32'd2);
        result_ready = 1'b1;
      end
      tick();
      check_eq("bp_sel_next", 32'(a_sel), 32'(k + 1));
    end
    repeat (43) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy",  32'(a_busy), 32'd0);
    check_eq("abort_valid", 32'(a_valid), 32'd0);
    check_eq("abort_done",  32'(a_done), 32'd0);
    check_eq("abort_sel",   32'(a_sel), 32'd5);
    seen = 1'b0;
    repeat (150) begin
      tick();
      if (a_valid || a_done || a_busy) seen = 1'b1;
    end
    check_eq("abort_quiet", 32'(seen), 32'd0);

    // Restart after abort; start while busy is ignored; then reset mid-sweep
    pulse_start();
    check_eq("restart_sel",  32'(a_sel), 32'd0);
    check_eq("restart_busy", 32'(a_busy), 32'd1);
    repeat (50) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(n);
    check_eq("busy_start_ignored", 32'(n), 32'd53);
    check_eq("busy_start_rsel", 32'(a_result_sel), 32'd0);
    tick();
    repeat (30) tick();
    check_eq("pre_rst_sel", 32'(a_sel), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_sel",   32'(a_sel), 32'd0);
    check_eq("mid_rst_busy",  32'(a_busy), 32'd0);
    check_eq("mid_rst_valid", 32'(a_valid), 32'd0);
    check_eq("mid_rst_res",   32'(a_result), 32'd0);
    seen = 1'b0;
    repeat (150) begin
      tick();
      if (a_valid || a_done) seen = 1'b1;
    end
    check_eq("rst_quiet", 32'(seen), 32'd0);

    // Boundaries: high level from last settle cycle; single rise on last gate cycle
    tog_en = 1'b0;
    pulse_in = 1'b0;
    result_ready = 1'b1;
    pulse_start();
    repeat (3) tick();
    pulse_in = 1'b1;
    wait_valid(n);
    check_eq("level_wait", 32'(n), 32'd101);
    check_eq("level_res", 32'(a_result), 32'd0);
    tick();
    pulse_in = 1'b0;
    repeat (103) tick();
    pulse_in = 1'b1;
    tick();
    check_eq("last_gate_valid", 32'(a_valid), 32'd1);
    check_eq("last_gate_res",   32'(a_result), 32'd1);
    check_eq("last_gate_rsel",  32'(a_result_sel), 32'd1);
    // Abort coinciding with the handshake
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("xfer_abort_busy",  32'(a_busy), 32'd0);
    check_eq("xfer_abort_valid", 32'(a_valid), 32'd0);
    check_eq("xfer_abort_done",  32'(a_done), 32'd0);
    check_eq("xfer_abort_sel",   32'(a_sel), 32'd1);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (a_done || a_busy) seen = 1'b1;
    end
    check_eq("xfer_abort_quiet", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
